// File: rtl/ram_pin_arbiter_pkg.sv
// Shared state encoding and frame constants for ram_pin_arbiter.
// Consumed by ram_pin_arbiter and rr_arbiter through a wildcard import.
package ram_pin_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        WAIT,
        DATA,
        RESP
    } state_t;

    localparam int DEF_RAM_PINS  = 4;
    localparam int DEF_ADDR_BITS = 16;
    localparam int DEF_DATA_BITS = 16;

    // First nibble of every frame; the RAM uses it to find the frame boundary.
    localparam int START_NIBBLE = 1;

    // Wide enough for any address/data/latency nibble count we support.
    localparam int CNT_W = 8;

    function automatic int nibbles(input int bits, input int pins);
        return bits / pins;
    endfunction

    localparam int ADDR_NIBBLES = nibbles(DEF_ADDR_BITS, DEF_RAM_PINS);
    localparam int DATA_NIBBLES = nibbles(DEF_DATA_BITS, DEF_RAM_PINS);

endpackage

// File: rtl/ram_pin_arbiter_rr.sv
// rr_arbiter: combinational one-hot grant picked from the valid vector and a search pointer.
// With RAM_PIN_ARBITER_FIXED_PRIO_EN defined the pointer is ignored and the lowest index wins.
module rr_arbiter
    import ram_pin_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int w_best_dist;
    int w_dist;

`ifdef RAM_PIN_ARBITER_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
`endif

    // The winner is the valid requester nearest to the pointer, walking upward with wrap.
    always_comb begin
        o_idx       = '0;
        w_best_dist = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef RAM_PIN_ARBITER_FIXED_PRIO_EN
            w_dist = i;
`else
            w_dist = (i + NUM_REQ - int'(i_ptr)) % NUM_REQ;
`endif
            if (i_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_idx       = IDX_W'(i);
            end
        end
        o_any = (w_best_dist < NUM_REQ);
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/ram_pin_arbiter.sv
// ram_pin_arbiter: shares the nibble-serial RAM pins between PPU read requesters.
// Optional macro RAM_PIN_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority.
module ram_pin_arbiter
    import ram_pin_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int RAM_PINS     = DEF_RAM_PINS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BITS-1:0]         rsp_data,
    output logic [RAM_PINS-1:0]          addr_pins,
    input  logic [RAM_PINS-1:0]          data_pins,
    output logic                         busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ANIB  = nibbles(ADDR_BITS, RAM_PINS);
    localparam int DNIB  = nibbles(DATA_BITS, RAM_PINS);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_data;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_ptr;
    logic [RAM_PINS-1:0]    r_pins;

    state_t                 w_state_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [ADDR_BITS-1:0]   w_addr_next;
    logic [DATA_BITS-1:0]   w_data_next;
    logic [IDX_W-1:0]       w_idx_next;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [RAM_PINS-1:0]    w_pins_next;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_any;
    logic                   w_handshake;
    logic [ADDR_BITS-1:0]   w_sel_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // Grants only exist in IDLE; reset also forces them low since IDLE is the reset state.
    assign req_ready   = (rst_n && (r_state == IDLE)) ? w_grant : '0;
    assign w_handshake = (r_state == IDLE) && w_grant_any;
    assign busy        = (r_state != IDLE);
    assign addr_pins   = r_pins;
    assign rsp_data    = r_data;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (r_state == RESP) && (r_idx == IDX_W'(i));
        end
    end

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Frame sequencer: the pin value is computed one cycle ahead so addr_pins comes straight from a flop.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_idx_next   = r_idx;
        w_ptr_next   = r_ptr;
        w_pins_next  = '0;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_state_next = START;
                    w_addr_next  = w_sel_addr;
                    w_idx_next   = w_grant_idx;
                    w_pins_next  = RAM_PINS'(START_NIBBLE);
`ifdef RAM_PIN_ARBITER_FIXED_PRIO_EN
                    w_ptr_next   = '0;
`else
                    w_ptr_next   = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                        : w_grant_idx + IDX_W'(1);
`endif
                end
            end
            START: begin
                w_state_next = ADDR;
                w_cnt_next   = '0;
                w_pins_next  = r_addr[RAM_PINS-1:0];
                w_addr_next  = r_addr >> RAM_PINS;
            end
            ADDR: begin
                if (r_cnt == CNT_W'(ANIB - 1)) begin
                    w_state_next = WAIT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_pins_next  = r_addr[RAM_PINS-1:0];
                    w_addr_next  = r_addr >> RAM_PINS;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(READ_LATENCY - 1)) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                // Nibbles enter at the top so the first one ends up least significant.
                w_data_next                         = r_data >> RAM_PINS;
                w_data_next[DATA_BITS-1 -: RAM_PINS] = data_pins;
                if (r_cnt == CNT_W'(DNIB - 1)) begin
                    w_state_next = RESP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_pins  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_idx   <= w_idx_next;
            r_ptr   <= w_ptr_next;
            r_pins  <= w_pins_next;
        end
    end

endmodule

// File: tb/tb_ram_pin_arbiter.sv
// Testbench for ram_pin_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level frame model.
module tb_ram_pin_arbiter;

    localparam int NR = 3;
    localparam int AB = 16;
    localparam int DB = 16;
    localparam int RP = 4;
    localparam int RL = 2;
    localparam int AN = AB / RP;
    localparam int DN = DB / RP;
    // Frame positions counted from the handshake edge (cycle 0).
    localparam int P_ADDR0 = 2;
    localparam int P_WAIT0 = P_ADDR0 + AN;
    localparam int P_DATA0 = P_WAIT0 + RL;
    localparam int P_RESP  = P_DATA0 + DN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AB-1:0] req_addr = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DB-1:0]    rsp_data;
    logic [RP-1:0]    addr_pins;
    logic [RP-1:0]    data_pins = '0;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    int      m_pos;
    int      m_ptr;
    int      m_idx;
    bit      m_granted;
    bit      m_force;
    logic [AB-1:0] m_addr;
    logic [DB-1:0] m_word;
    logic [DB-1:0] m_hold;
    logic [DB-1:0] m_force_word;

    always #5 clk = ~clk;

    ram_pin_arbiter #(
        .NUM_REQ      (NR),
        .RAM_PINS     (RP),
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB),
        .READ_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .addr_pins (addr_pins),
        .data_pins (data_pins),
        .busy      (busy)
    );

    // Arbitration rule: first valid requester found searching upward from start, wrapping.
    function automatic int pick(input logic [NR-1:0] v, input int start);
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (start + i) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int k);
        logic [NR-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_pos     = 0;
        m_ptr     = 0;
        m_idx     = 0;
        m_granted = 1'b0;
        m_force   = 1'b0;
        m_hold    = '0;
        m_word    = '0;
        m_addr    = '0;
    endtask

    // One clock cycle: drive data_pins from the model, check outputs, advance the model.
    task automatic tick();
        logic [NR-1:0] e_ready;
        logic [NR-1:0] e_rsp;
        logic [RP-1:0] e_pins;
        int g;
        if (m_pos >= P_DATA0 && m_pos < P_RESP)
            data_pins = m_word[(m_pos - P_DATA0)*RP +: RP];
        else
            data_pins = RP'($urandom);
        #1;
        g       = (m_pos == 0) ? pick(req_valid, m_ptr) : -1;
        e_ready = onehot(g);
        if (m_pos == 1)
            e_pins = RP'(1);
        else if (m_pos >= P_ADDR0 && m_pos < P_WAIT0)
            e_pins = m_addr[(m_pos - P_ADDR0)*RP +: RP];
        else
            e_pins = '0;
        e_rsp = (m_pos == P_RESP) ? onehot(m_idx) : '0;

        n_tests++;
        if (req_ready !== e_ready) begin
            n_fail++;
            $display("[TB] FAIL req_ready: got %b want %b (pos %0d)", req_ready, e_ready, m_pos);
        end
        n_tests++;
        if (addr_pins !== e_pins) begin
            n_fail++;
            $display("[TB] FAIL addr_pins: got %h want %h (pos %0d)", addr_pins, e_pins, m_pos);
        end
        n_tests++;
        if (busy !== (m_pos != 0)) begin
            n_fail++;
            $display("[TB] FAIL busy: got %b want %b (pos %0d)", busy, (m_pos != 0), m_pos);
        end
        n_tests++;
        if (rsp_valid !== e_rsp) begin
            n_fail++;
            $display("[TB] FAIL rsp_valid: got %b want %b (pos %0d)", rsp_valid, e_rsp, m_pos);
        end
        if (m_pos == P_RESP) begin
            n_tests++;
            if (rsp_data !== m_word) begin
                n_fail++;
                $display("[TB] FAIL rsp_data: got %h want %h", rsp_data, m_word);
            end
        end else if (m_pos < P_DATA0) begin
            n_tests++;
            if (rsp_data !== m_hold) begin
                n_fail++;
                $display("[TB] FAIL rsp_data_hold: got %h want %h (pos %0d)", rsp_data, m_hold, m_pos);
            end
        end

        m_granted = 1'b0;
        if (m_pos == 0) begin
            if (g >= 0) begin
                m_idx     = g;
                m_addr    = req_addr[g*AB +: AB];
                m_word    = m_force ? m_force_word : DB'($urandom);
                m_force   = 1'b0;
`ifdef RAM_PIN_ARBITER_FIXED_PRIO_EN
                m_ptr     = 0;
`else
                m_ptr     = (g + 1) % NR;
`endif
                m_pos     = 1;
                m_granted = 1'b1;
            end
        end else if (m_pos == P_RESP) begin
            m_pos  = 0;
            m_hold = m_word;
        end else begin
            m_pos++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = '1;
        @(negedge clk);
        #1;
        n_tests++;
        if (addr_pins !== '0) begin n_fail++; $display("[TB] FAIL reset addr_pins: got %h want 0", addr_pins); end
        n_tests++;
        if (req_ready !== '0) begin n_fail++; $display("[TB] FAIL reset req_ready: got %b want 000", req_ready); end
        n_tests++;
        if (rsp_valid !== '0) begin n_fail++; $display("[TB] FAIL reset rsp_valid: got %b want 000", rsp_valid); end
        n_tests++;
        if (rsp_data !== '0) begin n_fail++; $display("[TB] FAIL reset rsp_data: got %h want 0", rsp_data); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        model_reset();
    endtask

    task automatic test_single_read();
        logic [RP-1:0] got[5];
        logic [RP-1:0] want[5];
        want = '{4'h1, 4'h3, 4'hC, 4'h5, 4'hA};
        req_addr[AB +: AB] = 16'hA5C3;
        req_valid    = 3'b010;
        m_force      = 1'b1;
        m_force_word = 16'h0123;
        tick();
        req_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 5) begin
                #1;
                got[c-1] = addr_pins;
            end
            if (c == 12) begin
                #1;
                n_tests++;
                if (rsp_valid !== 3'b010) begin n_fail++; $display("[TB] FAIL single rsp_valid: got %b want 010", rsp_valid); end
                n_tests++;
                if (rsp_data !== 16'h0123) begin n_fail++; $display("[TB] FAIL single rsp_data: got %h want 0123", rsp_data); end
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL single frame nibble %0d: got %h want %h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_contention();
        int order[6];
`ifdef RAM_PIN_ARBITER_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 0, 1, 2};
`endif
        apply_reset();
        req_addr  = {AB'($urandom), AB'($urandom), AB'($urandom)};
        req_valid = '1;
        for (int f = 0; f < 6; f++) begin
            #1;
            n_tests++;
            if (req_ready !== onehot(order[f])) begin
                n_fail++;
                $display("[TB] FAIL contention grant %0d: got %b want %b", f, req_ready, onehot(order[f]));
            end
            tick();
            req_addr[m_idx*AB +: AB] = AB'($urandom);
            repeat (12) tick();
        end
        req_valid = '0;
    endtask

    task automatic test_addr_stability();
        logic [AB-1:0] a;
        logic [RP-1:0] got;
        a = AB'($urandom);
        req_addr[0 +: AB] = a;
        req_valid = 3'b001;
        tick();
        req_addr[0 +: AB] = ~a;
        req_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 2 && c <= 5) begin
                #1;
                got = addr_pins;
                n_tests++;
                if (got !== a[(c-2)*RP +: RP]) begin
                    n_fail++;
                    $display("[TB] FAIL addr stability nibble %0d: got %h want %h", c - 2, got, a[(c-2)*RP +: RP]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req_addr[AB +: AB] = AB'($urandom);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (addr_pins !== '0) begin n_fail++; $display("[TB] FAIL midreset addr_pins: got %h want 0", addr_pins); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset busy: got %b want 0", busy); end
        n_tests++;
        if (rsp_valid !== '0) begin n_fail++; $display("[TB] FAIL midreset rsp_valid: got %b want 000", rsp_valid); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) tick();
        req_valid = '1;
        #1;
        n_tests++;
        if (req_ready !== 3'b001) begin n_fail++; $display("[TB] FAIL midreset first grant: got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        repeat (12) tick();
    endtask

    task automatic test_withdraw_idle();
        apply_reset();
        req_addr  = {AB'($urandom), AB'($urandom), AB'($urandom)};
        req_valid = 3'b100;
        tick();
        req_valid = 3'b101;
        repeat (5) tick();
        req_valid = 3'b100;
        repeat (7) tick();
        #1;
        n_tests++;
        if (req_ready !== 3'b100) begin n_fail++; $display("[TB] FAIL withdraw grant: got %b want 100", req_ready); end
        tick();
        req_valid = '0;
        repeat (12) tick();
        for (int c = 0; c < 20; c++) begin
            #1;
            n_tests++;
            if (addr_pins !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL idle quiet cycle %0d: pins %h busy %b want 0 0", c, addr_pins, busy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_addr[i*AB +: AB] = AB'($urandom);
                    end
                end else if ($urandom_range(19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            tick();
            if (m_granted) req_valid[m_idx] = 1'b0;
        end
        req_valid = '0;
        repeat (14) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_contention();
        test_addr_stability();
        test_reset_mid();
        test_withdraw_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
